// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter stage with carry ripple, per-digit set and checked load.
module bcd_mod_counter #(
  parameter int unsigned MODULUS = 60
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       cin_i,
  input  logic       sel_down_i,
  input  logic       base_i,
  input  logic       bap_btn3_i,
  input  logic       settime1_i,
  input  logic       settime10_i,
  input  logic       load_i,
  input  logic [3:0] load_1_i,
  input  logic [3:0] load_10_i,
  output logic [3:0] count_1_o,
  output logic [3:0] count_10_o,
  output logic       cout_o,
  output logic       zero_o,
  output logic       load_err_o
);

  localparam int unsigned DW    = 4;
  localparam int unsigned VW    = 8;
  localparam int unsigned TMAX  = (MODULUS - 1) / 10;
  localparam int unsigned OLAST = (MODULUS - 1) % 10;

  localparam logic [DW-1:0] TMAX_D  = DW'(TMAX);
  localparam logic [DW-1:0] OLAST_D = DW'(OLAST);
  localparam logic [DW-1:0] NINE_D  = DW'(9);
  localparam logic [VW-1:0] MOD_V   = VW'(MODULUS);

  logic [DW-1:0] ones_q, ones_d;
  logic [DW-1:0] tens_q, tens_d;
  logic          load_err_q, load_err_d;

  logic          run_step;
  logic          set_step;
  logic          term_up;
  logic          term_dn;
  logic          load_ok;
  logic [VW-1:0] load_val;
  logic [DW-1:0] omax;
  logic [DW-1:0] tens_set;

  // Terminal detection, load validation and set-mode limits.
  always_comb begin
    run_step = base_i & enable_i & cin_i;
    set_step = ~base_i & bap_btn3_i;
    term_up  = (tens_q == TMAX_D) && (ones_q == OLAST_D);
    term_dn  = (tens_q == '0) && (ones_q == '0);
    load_val = VW'(load_10_i) * VW'(10) + VW'(load_1_i);
    load_ok  = (load_1_i <= NINE_D) && (load_10_i <= NINE_D) && (load_val < MOD_V);
    omax     = (tens_q == TMAX_D) ? OLAST_D : NINE_D;
    if (sel_down_i) tens_set = (tens_q == '0) ? TMAX_D : tens_q - DW'(1);
    else            tens_set = (tens_q == TMAX_D) ? '0 : tens_q + DW'(1);
  end

  // Next-state selection: reset > load > run step > set step.
  always_comb begin
    ones_d     = ones_q;
    tens_d     = tens_q;
    load_err_d = 1'b0;
    if (reset_i) begin
      ones_d = '0;
      tens_d = '0;
    end else if (load_i) begin
      if (load_ok) begin
        ones_d = load_1_i;
        tens_d = load_10_i;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (run_step) begin
      if (!sel_down_i) begin
        if (term_up) begin
          ones_d = '0;
          tens_d = '0;
        end else if (ones_q == NINE_D) begin
          ones_d = '0;
          tens_d = tens_q + DW'(1);
        end else begin
          ones_d = ones_q + DW'(1);
        end
      end else begin
        if (term_dn) begin
          ones_d = OLAST_D;
          tens_d = TMAX_D;
        end else if (ones_q == '0) begin
          ones_d = NINE_D;
          tens_d = tens_q - DW'(1);
        end else begin
          ones_d = ones_q - DW'(1);
        end
      end
    end else if (set_step) begin
      if (settime10_i) begin
        tens_d = tens_set;
        // Landing on the top tens digit may push the value out of range.
        if ((tens_set == TMAX_D) && (ones_q > OLAST_D)) ones_d = OLAST_D;
      end else if (settime1_i) begin
        if (sel_down_i) ones_d = (ones_q == '0) ? omax : ones_q - DW'(1);
        else            ones_d = (ones_q >= omax) ? '0 : ones_q + DW'(1);
      end
    end
  end

  // State registers with synchronous reset folded into next-state logic.
  always_ff @(posedge clk_i) begin
    ones_q     <= ones_d;
    tens_q     <= tens_d;
    load_err_q <= load_err_d;
  end

  assign count_1_o  = ones_q;
  assign count_10_o = tens_q;
  assign load_err_o = load_err_q;
  assign zero_o     = term_dn;
  assign cout_o     = run_step & ~reset_i & ~load_i & (sel_down_i ? term_dn : term_up);

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter at moduli 60, 24 and 100 sharing one stimulus bus.
module tb_bcd_mod_counter;

  logic       clk = 1'b0;
  logic       reset, enable, cin, sel_down, base, bap, st1, st10, load;
  logic [3:0] ld1, ld10;

  logic [3:0] c1_a, c10_a, c1_b, c10_b, c1_c, c10_c;
  logic       cout_a, zero_a, err_a, cout_b, zero_b, err_b, cout_c, zero_c, err_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(.MODULUS(60)) u_m60 (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .cin_i(cin), .sel_down_i(sel_down),
    .base_i(base), .bap_btn3_i(bap), .settime1_i(st1), .settime10_i(st10), .load_i(load),
    .load_1_i(ld1), .load_10_i(ld10), .count_1_o(c1_a), .count_10_o(c10_a),
    .cout_o(cout_a), .zero_o(zero_a), .load_err_o(err_a));

  bcd_mod_counter #(.MODULUS(24)) u_m24 (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .cin_i(cin), .sel_down_i(sel_down),
    .base_i(base), .bap_btn3_i(bap), .settime1_i(st1), .settime10_i(st10), .load_i(load),
    .load_1_i(ld1), .load_10_i(ld10), .count_1_o(c1_b), .count_10_o(c10_b),
    .cout_o(cout_b), .zero_o(zero_b), .load_err_o(err_b));

  bcd_mod_counter #(.MODULUS(100)) u_m100 (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .cin_i(cin), .sel_down_i(sel_down),
    .base_i(base), .bap_btn3_i(bap), .settime1_i(st1), .settime10_i(st10), .load_i(load),
    .load_1_i(ld1), .load_10_i(ld10), .count_1_o(c1_c), .count_10_o(c10_c),
    .cout_o(cout_c), .zero_o(zero_c), .load_err_o(err_c));

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1;
    ld10 = t;
    ld1  = o;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cin = 1'b0; sel_down = 1'b0; base = 1'b1;
    bap = 1'b0; st1 = 1'b0; st10 = 1'b0; load = 1'b0; ld1 = '0; ld10 = '0;
    tick();
    tick();
    check("rst_cnt60", int'({c10_a, c1_a}), 'h00);
    check("rst_cnt100", int'({c10_c, c1_c}), 'h00);
    check("rst_err24", int'(err_b), 0);
    check("rst_zero60", int'(zero_a), 1);
    reset = 1'b0;

    // M=60 up through the wrap.
    do_load(4'd5, 4'd8);
    check("m60_ld58", int'({c10_a, c1_a}), 'h58);
    enable = 1'b1; cin = 1'b1; base = 1'b1; sel_down = 1'b0;
    #1;
    check("m60_cout58", int'(cout_a), 0);
    tick();
    check("m60_cnt59", int'({c10_a, c1_a}), 'h59);
    check("m60_cout59", int'(cout_a), 1);
    load = 1'b1; ld10 = 4'd0; ld1 = 4'd7;
    #1;
    check("m60_cout_load", int'(cout_a), 0);
    load = 1'b0;
    #1;
    tick();
    check("m60_wrap00", int'({c10_a, c1_a}), 'h00);
    check("m60_cout00", int'(cout_a), 0);
    check("m60_zero00", int'(zero_a), 1);

    // M=24 down from 00.
    enable = 1'b0;
    do_load(4'd0, 4'd0);
    enable = 1'b1; sel_down = 1'b1;
    #1;
    check("m24_cout00", int'(cout_b), 1);
    tick();
    check("m24_dn23", int'({c10_b, c1_b}), 'h23);
    check("m24_cout23", int'(cout_b), 0);
    tick();
    check("m24_dn22", int'({c10_b, c1_b}), 'h22);
    check("m24_cout22", int'(cout_b), 0);

    // M=24 set mode, tens step with clamp.
    enable = 1'b0; sel_down = 1'b0;
    do_load(4'd1, 4'd9);
    base = 1'b0; bap = 1'b1; st10 = 1'b1; st1 = 1'b0;
    tick();
    check("m24_set10_clamp", int'({c10_b, c1_b}), 'h23);
    tick();
    check("m24_set10_wrap", int'({c10_b, c1_b}), 'h03);
    bap = 1'b0; st10 = 1'b0;

    // M=24 set mode, ones step limited by OLAST.
    do_load(4'd2, 4'd3);
    bap = 1'b1; st1 = 1'b1;
    tick();
    check("m24_set1_up", int'({c10_b, c1_b}), 'h20);
    sel_down = 1'b1;
    tick();
    check("m24_set1_dn", int'({c10_b, c1_b}), 'h23);
    bap = 1'b0; st1 = 1'b0; sel_down = 1'b0;

    // M=24 load validation.
    do_load(4'd2, 4'd5);
    check("m24_err25", int'(err_b), 1);
    check("m24_hold25", int'({c10_b, c1_b}), 'h23);
    tick();
    check("m24_err_clr", int'(err_b), 0);
    do_load(4'd1, 4'hA);
    check("m24_err1A", int'(err_b), 1);
    check("m24_hold1A", int'({c10_b, c1_b}), 'h23);
    do_load(4'd1, 4'd7);
    check("m24_ld17", int'({c10_b, c1_b}), 'h17);
    check("m24_err17", int'(err_b), 0);

    // No carry out in set mode even at terminal value.
    do_load(4'd0, 4'd0);
    base = 1'b0; enable = 1'b1; cin = 1'b1; sel_down = 1'b1;
    #1;
    check("m24_cout_set", int'(cout_b), 0);
    enable = 1'b0; sel_down = 1'b0; base = 1'b1;

    // M=100 reset dominance over load and pending error.
    do_load(4'd4, 4'd2);
    enable = 1'b1;
    tick();
    check("m100_cnt43", int'({c10_c, c1_c}), 'h43);
    enable = 1'b0;
    do_load(4'd1, 4'hA);
    check("m100_err", int'(err_c), 1);
    reset = 1'b1; load = 1'b1; ld10 = 4'd1; ld1 = 4'hA;
    tick();
    check("m100_rst_cnt", int'({c10_c, c1_c}), 'h00);
    check("m100_rst_err", int'(err_c), 0);
    reset = 1'b0; load = 1'b0;

    // M=100 top of range wraps.
    do_load(4'd9, 4'd9);
    enable = 1'b1; cin = 1'b1;
    #1;
    check("m100_cout99", int'(cout_c), 1);
    tick();
    check("m100_wrap", int'({c10_c, c1_c}), 'h00);
    enable = 1'b0;

    // M=60 holds while ENABLE or CIN low.
    do_load(4'd2, 4'd5);
    base = 1'b1; enable = 1'b0; cin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("m60_hold_en", int'(cout_a), 0);
    end
    enable = 1'b1; cin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("m60_hold_cin", int'(cout_a), 0);
    end
    check("m60_hold_cnt", int'({c10_a, c1_a}), 'h25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
